// File: rtl/ising_pkg.sv
// Shared definitions for the Ising run controller: FSM state encoding and
// the cell-address width helper.
package ising_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VREQ,
        S_VCMP,
        S_RUN,
        S_CAPT
    } state_t;

    function automatic int cell_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ising_run_controller_phase_sync.sv
// N-bit two-flop synchroniser bringing the asynchronous oscillator phases
// into the clk domain; runs continuously and resets to zero.
module phase_sync #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] async_in,
    output logic [N-1:0] sync_out
);

    logic [N-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/ising_run_controller.sv
// Sequencer for one Ising coupling matrix: programs cell weights, runs the
// oscillators for a set number of cycles and captures the phase vector.
// Optional read-back check of each written cell: ISING_READBACK_VERIFY_EN.
module ising_run_controller
    import ising_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = cell_addr_w(N)
) (
    input  logic              clk,
    input  logic              axi_rstn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_s_addr,
    input  logic [ADDR_W-1:0] cfg_d_addr,
    input  logic [31:0]       cfg_data,
    input  logic              start,
    input  logic [31:0]       run_cycles,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              err_addr,
    output logic              err_verify,
    output logic              ising_rstn,
    output logic              wready,
    output logic              wr_match,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] d_addr,
    output logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    input  logic [N-1:0]      right_col
);

    state_t       state;
    logic [31:0]  count;
    logic [N-1:0] phase;

    phase_sync #(.N(N)) u_phase_sync (
        .clk      (clk),
        .rstn     (axi_rstn),
        .async_in (right_col),
        .sync_out (phase)
    );

`ifndef ISING_READBACK_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^rdata;
    assign err_verify   = 1'b0;
`endif

    // NOTE: all state and outputs update with non-blocking assignments so every
    // registered output reflects the same edge; outputs are set for the state
    // being entered, not the state being left.
    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            state      <= S_IDLE;
            count      <= '0;
            cfg_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_addr   <= 1'b0;
            ising_rstn <= 1'b0;
            wready     <= 1'b0;
            wr_match   <= 1'b0;
            s_addr     <= '0;
            d_addr     <= '0;
            wdata      <= '0;
            result     <= '0;
`ifdef ISING_READBACK_VERIFY_EN
            err_verify <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // cfg_ready is always high here, so cfg_valid alone means
                    // acceptance and takes priority over start.
                    if (cfg_valid) begin
                        s_addr <= cfg_s_addr;
                        d_addr <= cfg_d_addr;
                        wdata  <= cfg_data;
                        if (cfg_s_addr >= cfg_d_addr) begin
                            state     <= S_WRITE;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            wr_match  <= 1'b1;
                            wready    <= 1'b1;
                        end else begin
                            err_addr <= 1'b1;
                        end
                    end else if (start) begin
                        count      <= (run_cycles == 32'd0) ? 32'd1 : run_cycles;
                        ising_rstn <= 1'b1;
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_WRITE: begin
                    wready <= 1'b0;
`ifdef ISING_READBACK_VERIFY_EN
                    state <= S_VREQ;
`else
                    wr_match  <= 1'b0;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
`endif
                end
`ifdef ISING_READBACK_VERIFY_EN
                S_VREQ: state <= S_VCMP;
                S_VCMP: begin
                    if (rdata != wdata) err_verify <= 1'b1;
                    wr_match  <= 1'b0;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
`endif
                S_RUN: begin
                    count <= count - 32'd1;
                    // Capture on the last RUN edge so result and done are
                    // valid during CAPT, right after the enable window.
                    if (count == 32'd1) begin
                        ising_rstn <= 1'b0;
                        result     <= phase;
                        done       <= 1'b1;
                        state      <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    ising_rstn <= 1'b0;
                    wready     <= 1'b0;
                    wr_match   <= 1'b0;
                    cfg_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ising_run_controller.sv
// Directed self-checking bench for ising_run_controller; verify-path steps
// are active only when ISING_READBACK_VERIFY_EN is defined.
module tb_ising_run_controller;

    localparam int N      = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              axi_rstn;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_s_addr;
    logic [ADDR_W-1:0] cfg_d_addr;
    logic [31:0]       cfg_data;
    logic              start;
    logic [31:0]       run_cycles;
    logic              busy;
    logic              done;
    logic [N-1:0]      result;
    logic              err_addr;
    logic              err_verify;
    logic              ising_rstn;
    logic              wready;
    logic              wr_match;
    logic [ADDR_W-1:0] s_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [N-1:0]      right_col;

    int total = 0;
    int bad   = 0;

    ising_run_controller #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .axi_rstn   (axi_rstn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_s_addr (cfg_s_addr),
        .cfg_d_addr (cfg_d_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .run_cycles (run_cycles),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err_addr   (err_addr),
        .err_verify (err_verify),
        .ising_rstn (ising_rstn),
        .wready     (wready),
        .wr_match   (wr_match),
        .s_addr     (s_addr),
        .d_addr     (d_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .right_col  (right_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_entry(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input logic [31:0] data);
        cfg_valid  = 1'b1;
        cfg_s_addr = s;
        cfg_d_addr = d;
        cfg_data   = data;
        tick();
        cfg_valid  = 1'b0;
    endtask

    // Counts cycles with ising_rstn high, leaving the bench in the first low cycle.
    task automatic count_run(output int cycles);
        int guard;
        cycles = 0;
        guard  = 0;
        while (ising_rstn === 1'b1 && guard < 200) begin
            cycles++;
            guard++;
            tick();
        end
    endtask

    initial begin
        int cycles;
        int seen;

        axi_rstn   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_s_addr = '0;
        cfg_d_addr = '0;
        cfg_data   = '0;
        start      = 1'b0;
        run_cycles = '0;
        rdata      = '0;
        right_col  = '0;
        tick();
        tick();

        check("rst_cfg_ready",  cfg_ready,  1);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        check("rst_err_addr",   err_addr,   0);
        check("rst_err_verify", err_verify, 0);
        check("rst_ising_rstn", ising_rstn, 0);
        check("rst_strobes",    {wready, wr_match}, 0);
        check("rst_addr_data",  {s_addr, d_addr, wdata}, 0);
        check("rst_result",     result,     0);
        axi_rstn = 1'b1;
        tick();

        // Valid upper-triangle entry.
        rdata = 32'h13;
        send_entry(3'd5, 3'd2, 32'h0000_0013);
        check("wr_strobes",   {wr_match, wready}, 2'b11);
        check("wr_addr",      {s_addr, d_addr}, {3'd5, 3'd2});
        check("wr_data",      wdata, 32'h13);
        check("wr_busy",      {busy, cfg_ready}, 2'b10);
        tick();
        check("wr_wready_off", wready, 0);
`ifdef ISING_READBACK_VERIFY_EN
        check("vreq_match", wr_match, 1);
        tick();
        tick();
        check("v_ok_err", err_verify, 0);
`else
        check("wr_match_off", wr_match, 0);
`endif
        check("wr_back_idle", {cfg_ready, busy}, 2'b10);

        // Lower-triangle entry is dropped.
        send_entry(3'd1, 3'd6, 32'hDEAD_BEEF);
        check("drop_strobes",  {wr_match, wready}, 2'b00);
        check("drop_err_addr", err_addr, 1);
        check("drop_ready",    {cfg_ready, busy}, 2'b10);

        // Diagonal entry is written.
        rdata = 32'h7;
        send_entry(3'd3, 3'd3, 32'h7);
        check("diag_strobes", {wr_match, wready}, 2'b11);
        check("diag_addr",    {s_addr, d_addr}, {3'd3, 3'd3});
        check("diag_data",    wdata, 32'h7);
        tick();
`ifdef ISING_READBACK_VERIFY_EN
        tick();
        tick();
`endif
        check("err_addr_sticky", err_addr, 1);

`ifdef ISING_READBACK_VERIFY_EN
        rdata = 32'hAAAA_AAAA;
        send_entry(3'd4, 3'd0, 32'h5);
        tick();
        tick();
        check("v_bad_pending", err_verify, 0);
        tick();
        check("v_bad_err", err_verify, 1);
        check("v_bad_idle", cfg_ready, 1);
`endif

        // Run of 10 cycles with a steady phase pattern.
        right_col = 8'hA5;
        tick();
        tick();
        tick();
        run_cycles = 32'd10;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("run10_busy", {busy, cfg_ready}, 2'b10);
        count_run(cycles);
        check("run10_len",    cycles, 10);
        check("run10_done",   done, 1);
        check("run10_result", result, 8'hA5);
        tick();
        check("run10_done_off", done, 0);
        check("run10_idle",     {busy, cfg_ready}, 2'b01);

        // run_cycles = 0 behaves as 1.
        right_col = 8'h3C;
        tick();
        tick();
        tick();
        run_cycles = 32'd0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        count_run(cycles);
        check("run0_len",    cycles, 1);
        check("run0_done",   done, 1);
        check("run0_result", result, 8'h3C);
        tick();

        // Entry and start together: entry wins, no run.
        rdata      = 32'h21;
        run_cycles = 32'd5;
        start      = 1'b1;
        send_entry(3'd6, 3'd1, 32'h21);
        start      = 1'b0;
        check("both_strobes", {wr_match, wready}, 2'b11);
        check("both_addr",    {s_addr, d_addr}, {3'd6, 3'd1});
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (ising_rstn !== 1'b0 || done !== 1'b0) seen++;
            tick();
        end
        check("both_no_run", seen, 0);
        check("both_result_kept", result, 8'h3C);

        // Reset in the middle of a run.
        run_cycles = 32'd20;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        tick();
        tick();
        tick();
        check("mid_running", {ising_rstn, busy}, 2'b11);
        axi_rstn = 1'b0;
        tick();
        check("mid_rst_ising", ising_rstn, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_done",  done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_err",   err_addr, 0);
        axi_rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ising_rstn !== 1'b0 || done !== 1'b0) seen++;
        end
        check("mid_no_resume", seen, 0);
        check("mid_ready", cfg_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
